// File: rtl/l2_prefetch_unit.sv
// -----------------------------------------------------------------------------
// l2_prefetch_unit
//
// Next-line prefetcher on the initiator side of the L2 prefetch port. When
// the L2 starts a demand miss, this block computes line+1. When the L2 is not
// using physical memory, it reads that line over its own pmem port. It then
// offers the block to the L2 until the L2 installs or declines it.
//
// Optional feature macro: PREFETCH_FILTER_EN
//   When defined, the block remembers the last line it offered. A miss whose
//   target is that line is dropped. When undefined, every legal miss seen in
//   IDLE or WAIT is acted on.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   miss_valid          1-cycle pulse: L2 begins a demand fetch
//   miss_address[15:0]  byte address of that miss
//   l2_pmem_active      L2 owns physical memory; no new fetch may start
//   pf_mem_read         read request to physical memory (registered)
//   pf_mem_address      line-aligned read address (registered)
//   pf_mem_resp         physical memory read complete
//   pf_mem_rdata        returned block
//   prefetch_ready      buffered block offered to L2 (registered)
//   prefetch_busy       high in FETCH and OFFER (registered)
//   prefetch_address    line-aligned address of offered block (registered)
//   prefetch_wdata      offered block (registered)
//   done_prefetch       L2 installed the block
//   no_prefetch         L2 declined the block
// -----------------------------------------------------------------------------
module l2_prefetch_unit #(
    parameter int line_size = 128,
    parameter int log_line  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_valid,
    input  logic [15:0]          miss_address,
    input  logic                 l2_pmem_active,
    output logic                 pf_mem_read,
    output logic [15:0]          pf_mem_address,
    input  logic                 pf_mem_resp,
    input  logic [line_size-1:0] pf_mem_rdata,
    output logic                 prefetch_ready,
    output logic                 prefetch_busy,
    output logic [15:0]          prefetch_address,
    output logic [line_size-1:0] prefetch_wdata,
    input  logic                 done_prefetch,
    input  logic                 no_prefetch
);

    localparam int LINE_W = 16 - log_line;

    typedef enum logic [1:0] {IDLE, WAIT, FETCH, OFFER} state_e;

    state_e                state_q, state_d;
    logic [LINE_W-1:0]     target_q, target_d;
    logic                  read_q, read_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [15:0]           pf_addr_q, pf_addr_d;
    logic [15:0]           pa_q, pa_d;
    logic [line_size-1:0]  wdata_q, wdata_d;

    logic [LINE_W-1:0]     miss_line;
    logic [LINE_W-1:0]     miss_tgt;
    logic                  miss_legal;
    logic                  miss_filtered;

    assign miss_line  = LINE_W'(miss_address >> log_line);
    // The last line has no successor inside the 16-bit space.
    assign miss_legal = (miss_line != '1);
    assign miss_tgt   = miss_line + LINE_W'(1);

`ifdef PREFETCH_FILTER_EN
    logic [LINE_W-1:0] last_q, last_d;
    logic              last_vld_q, last_vld_d;

    assign miss_filtered = last_vld_q && (miss_tgt == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (state_q == OFFER && (done_prefetch || no_prefetch)) begin
            last_d     = LINE_W'(pa_q >> log_line);
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign miss_filtered = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (miss_valid && miss_legal && !miss_filtered) begin
                    target_d = miss_tgt;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (miss_valid && !miss_legal) begin
                    state_d = IDLE;
                end else begin
                    // Latest miss wins. A busy L2 only delays the fetch; the
                    // new target still replaces the old one.
                    if (miss_valid && !miss_filtered) begin
                        target_d = miss_tgt;
                    end
                    if (!l2_pmem_active) begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (pf_mem_resp) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (done_prefetch || no_prefetch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state. This makes them line up
    // with the state register, with no combinational path to the ports.
    always_comb begin
        read_d    = (state_d == FETCH);
        ready_d   = (state_d == OFFER);
        busy_d    = (state_d == FETCH) || (state_d == OFFER);
        pf_addr_d = pf_addr_q;
        pa_d      = pa_q;
        wdata_d   = wdata_q;
        if (state_q == WAIT && state_d == FETCH) begin
            pf_addr_d = {target_d, {log_line{1'b0}}};
        end
        if (state_q == FETCH && pf_mem_resp) begin
            pa_d    = pf_addr_q;
            wdata_d = pf_mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= '0;
            read_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            pf_addr_q <= '0;
            pa_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            read_q    <= read_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            pf_addr_q <= pf_addr_d;
            pa_q      <= pa_d;
            wdata_q   <= wdata_d;
        end
    end

    assign pf_mem_read      = read_q;
    assign pf_mem_address   = pf_addr_q;
    assign prefetch_ready   = ready_q;
    assign prefetch_busy    = busy_q;
    assign prefetch_address = pa_q;
    assign prefetch_wdata   = wdata_q;

endmodule

// File: tb/tb_l2_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_l2_prefetch_unit
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model tracks the pending target, the in-flight read and the
// offered block. Every cycle, all DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_l2_prefetch_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         miss_valid = 1'b0;
    logic [15:0]  miss_address = '0;
    logic         l2_pmem_active = 1'b0;
    logic         pf_mem_read;
    logic [15:0]  pf_mem_address;
    logic         pf_mem_resp = 1'b0;
    logic [127:0] pf_mem_rdata = '0;
    logic         prefetch_ready;
    logic         prefetch_busy;
    logic [15:0]  prefetch_address;
    logic [127:0] prefetch_wdata;
    logic         done_prefetch = 1'b0;
    logic         no_prefetch = 1'b0;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic prev_read = 1'b0;

    // Reference model state
    logic         m_pend = 0, m_fetch = 0, m_offer = 0;
    logic [11:0]  m_tgt = '0;
    logic [11:0]  m_last = '0;
    logic         m_last_vld = 0;
    logic [15:0]  e_addr = '0, e_paddr = '0;
    logic [127:0] e_wdata = '0;

    l2_prefetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_address     (miss_address),
        .l2_pmem_active   (l2_pmem_active),
        .pf_mem_read      (pf_mem_read),
        .pf_mem_address   (pf_mem_address),
        .pf_mem_resp      (pf_mem_resp),
        .pf_mem_rdata     (pf_mem_rdata),
        .prefetch_ready   (prefetch_ready),
        .prefetch_busy    (prefetch_busy),
        .prefetch_address (prefetch_address),
        .prefetch_wdata   (prefetch_wdata),
        .done_prefetch    (done_prefetch),
        .no_prefetch      (no_prefetch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Applies one clock edge of the specification's rules to the model.
    task automatic model_step();
        logic [11:0] ml;
        logic [11:0] nt;
        logic        legal;
        logic        filt;
        ml    = miss_address[15:4];
        nt    = ml + 12'd1;
        legal = (ml != 12'hFFF);
        filt  = 1'b0;
`ifdef PREFETCH_FILTER_EN
        filt  = m_last_vld && (nt == m_last);
`endif
        if (reset) begin
            m_pend = 0; m_fetch = 0; m_offer = 0; m_tgt = '0;
            m_last = '0; m_last_vld = 0;
            e_addr = '0; e_paddr = '0; e_wdata = '0;
        end else if (m_offer) begin
            if (done_prefetch || no_prefetch) begin
                m_offer    = 0;
                m_last     = e_paddr[15:4];
                m_last_vld = 1;
            end
        end else if (m_fetch) begin
            if (pf_mem_resp) begin
                m_fetch = 0;
                m_offer = 1;
                e_paddr = e_addr;
                e_wdata = pf_mem_rdata;
            end
        end else if (!m_pend) begin
            if (miss_valid && legal && !filt) begin
                m_pend = 1;
                m_tgt  = nt;
            end
        end else begin
            if (miss_valid && !legal) begin
                m_pend = 0;
            end else begin
                if (miss_valid && !filt) m_tgt = nt;
                if (!l2_pmem_active) begin
                    m_pend  = 0;
                    m_fetch = 1;
                    e_addr  = {m_tgt, 4'h0};
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("read",  pf_mem_read,      m_fetch);
        chk("addr",  pf_mem_address,   e_addr);
        chk("ready", prefetch_ready,   m_offer);
        chk("busy",  prefetch_busy,    m_fetch || m_offer);
        chk("paddr", prefetch_address, e_paddr);
        chk("wdata", prefetch_wdata,   e_wdata);
        if (pf_mem_read && !prev_read) rises++;
        prev_read = pf_mem_read;
    endtask

    initial begin
        int r0;
        // 1. reset
        reset = 1; cyc(); cyc();
        chk("rst_read",  pf_mem_read, 1'b0);
        chk("rst_ready", prefetch_ready, 1'b0);
        chk("rst_addr",  pf_mem_address, 16'h0);
        chk("rst_wdata", prefetch_wdata, 128'h0);
        reset = 0;

        // 2. basic next-line fetch and offer
        miss_valid = 1; miss_address = 16'h1234; cyc();
        miss_valid = 0;
        chk("t2_wait_read", pf_mem_read, 1'b0);
        cyc();
        chk("t2_read", pf_mem_read, 1'b1);
        chk("t2_addr", pf_mem_address, 16'h1240);
        pf_mem_resp = 1; pf_mem_rdata = 128'hDEAD_BEEF; cyc();
        pf_mem_resp = 0;
        chk("t2_ready", prefetch_ready, 1'b1);
        chk("t2_paddr", prefetch_address, 16'h1240);
        chk("t2_wdata", prefetch_wdata, 128'hDEAD_BEEF);
        done_prefetch = 1; cyc();
        done_prefetch = 0;
        chk("t2_ready_drop", prefetch_ready, 1'b0);

        // 3. wrapping target is dropped
        miss_valid = 1; miss_address = 16'hFFF8; cyc();
        miss_valid = 0;
        repeat (4) cyc();
        chk("t3_read", pf_mem_read, 1'b0);
        chk("t3_busy", prefetch_busy, 1'b0);

        // 4. L2 holds memory; target replaced meanwhile
        r0 = rises;
        l2_pmem_active = 1;
        miss_valid = 1; miss_address = 16'h1000; cyc();
        miss_valid = 0; cyc();
        miss_valid = 1; miss_address = 16'h2000; cyc();
        miss_valid = 0; cyc(); cyc();
        chk("t4_held", pf_mem_read, 1'b0);
        l2_pmem_active = 0; cyc();
        chk("t4_read", pf_mem_read, 1'b1);
        chk("t4_addr", pf_mem_address, 16'h2010);
        pf_mem_resp = 1; pf_mem_rdata = {$urandom, $urandom, $urandom, $urandom}; cyc();
        pf_mem_resp = 0; done_prefetch = 1; cyc();
        done_prefetch = 0; repeat (3) cyc();
        chk("t4_nfetch", rises - r0, 1);

        // 5. decline, then repeat the same miss
        miss_valid = 1; miss_address = 16'h1234; cyc();
        miss_valid = 0; cyc();
        chk("t5_addr", pf_mem_address, 16'h1240);
        pf_mem_resp = 1; cyc();
        pf_mem_resp = 0; no_prefetch = 1; cyc();
        no_prefetch = 0;
        chk("t5_ready_drop", prefetch_ready, 1'b0);
        miss_valid = 1; miss_address = 16'h1234; cyc();
        miss_valid = 0; cyc();
`ifdef PREFETCH_FILTER_EN
        chk("t5_filtered", pf_mem_read, 1'b0);
`else
        chk("t5_refetch", pf_mem_read, 1'b1);
        chk("t5_refetch_addr", pf_mem_address, 16'h1240);
        pf_mem_resp = 1; cyc();
        pf_mem_resp = 0; done_prefetch = 1; cyc();
        done_prefetch = 0;
`endif

        // 6. reset during FETCH, late response
        miss_valid = 1; miss_address = 16'h3000; cyc();
        miss_valid = 0; cyc();
        chk("t6_read", pf_mem_read, 1'b1);
        reset = 1; cyc();
        reset = 0;
        chk("t6_read_drop", pf_mem_read, 1'b0);
        cyc(); cyc();
        pf_mem_resp = 1; pf_mem_rdata = 128'h1; cyc();
        pf_mem_resp = 0;
        chk("t6_ready", prefetch_ready, 1'b0);
        cyc();
        chk("t6_ready2", prefetch_ready, 1'b0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            miss_valid     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: miss_address = 16'h1234;
                1: miss_address = 16'h1240;
                2: miss_address = 16'hFFF0 | 16'($urandom_range(0, 15));
                3: miss_address = 16'h2000;
                default: miss_address = 16'($urandom);
            endcase
            l2_pmem_active = $urandom_range(0, 1);
            pf_mem_resp    = ($urandom_range(0, 3) == 0);
            pf_mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
            done_prefetch  = ($urandom_range(0, 4) == 0);
            no_prefetch    = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
